arith_rr_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one external add/multiply datapath among NREQ requesters. The datapath takes WIDTH-bit operands and has a fixed LAT-cycle latency to its add_result and mul_result outputs. The block accepts operations over valid/ready handshakes, issues one operation per cycle, and tracks in-flight operations with an id/op tag pipeline. It returns tagged results through a credit-protected response FIFO, so no result is ever dropped.

---
 rtl/arith_rr_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_arith_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_rr_arbiter.sv
// ---------------------------------------------------------------------------
// arith_rr_arbiter
//
// Shares one external add/multiply datapath among NREQ requesters. Requests
// are picked round-robin, one per cycle, and sent to the datapath as an issue
// strobe with two operands. The datapath answers LAT cycles after the strobe
// on both its sum and product outputs. A small tag pipeline remembers which
// requester each in-flight operation belongs to and whether it was an add or
// a multiply, so the right result can be captured into a response FIFO.
//
// A credit scheme keeps the FIFO from overflowing: a new request is only
// accepted while the number of operations held anywhere in the block (issue
// stage, tag pipeline, FIFO) is below the FIFO depth. Because of that, a
// result arriving from the datapath always has a free FIFO slot waiting.
//
// Ports:
//   i_clk          clock, rising edge
//   i_resetn       asynchronous active-low reset, released synchronously
//   i_req_valid    per-requester request valid
//   o_req_ready    per-requester accept, at most one bit high
//   i_req_op       per-requester op select, 0 = add, 1 = mul
//   i_req_a        packed operand A, requester k at [k*WIDTH +: WIDTH]
//   i_req_b        packed operand B, same packing
//   o_op_valid     issue strobe to the datapath
//   o_op_a         operand A to the datapath
//   o_op_b         operand B to the datapath
//   i_add_result   datapath sum (WIDTH+1 bits)
//   i_mul_result   datapath product (2*WIDTH bits)
//   o_rsp_valid    response FIFO not empty
//   o_rsp_id       requester id of the head response (0 when empty)
//   o_rsp_result   result of the head response (0 when empty)
//   i_rsp_ready    response consumer ready
// ---------------------------------------------------------------------------
module arith_rr_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ-1:0]         i_req_op,
  input  logic [NREQ*WIDTH-1:0]   i_req_a,
  input  logic [NREQ*WIDTH-1:0]   i_req_b,
  output logic                    o_op_valid,
  output logic [WIDTH-1:0]        o_op_a,
  output logic [WIDTH-1:0]        o_op_b,
  input  logic [WIDTH:0]          i_add_result,
  input  logic [2*WIDTH-1:0]      i_mul_result,
  output logic                    o_rsp_valid,
  output logic [IDW-1:0]          o_rsp_id,
  output logic [2*WIDTH-1:0]      o_rsp_result,
  input  logic                    i_rsp_ready
);

  localparam int RW = 2 * WIDTH;
  localparam int EW = IDW + RW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + LAT + 2) + 1;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW:0]    cand;
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;

  logic [OW-1:0]   occupancy;
  logic            issue_allowed;
  logic            accept;

  logic            issue_valid;
  logic [IDW-1:0]  issue_id;
  logic            issue_op;

  logic [LAT-1:0]  tag_valid;
  logic [LAT-1:0]  tag_op;
  logic [IDW-1:0]  tag_id [LAT];

  logic [RW-1:0]   capture_result;
  logic            fifo_push;
  logic            fifo_pop;
  logic [EW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   fifo_count;
  logic [EW-1:0]   fifo_head;

  // Round-robin search: walk the requesters starting at the pointer and
  // wrapping modulo NREQ, and take the first one that is asking. The
  // candidate index is one bit wider than an id so ptr+i never overflows
  // before the explicit wrap subtraction.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && i_req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Occupancy counts every operation the block is still responsible for:
  // results waiting in the FIFO, the operation being issued this cycle and
  // every tag travelling alongside the datapath. A pop this cycle only
  // frees its credit once the FIFO count actually drops at the next edge.
  always_comb begin
    occupancy = OW'(fifo_count) + OW'(issue_valid);
    for (int i = 0; i < LAT; i++) begin
      occupancy = occupancy + OW'(tag_valid[i]);
    end
  end

  assign issue_allowed = (occupancy < OW'(FIFO_DEPTH));

  // Ready goes to the granted requester only, and only when a credit is
  // free. It is forced low while reset is asserted so that every output of
  // the block reads zero during reset even if requesters keep asking.
  always_comb begin
    o_req_ready = '0;
    if (i_resetn && grant_found && issue_allowed) begin
      o_req_ready[grant_idx] = 1'b1;
    end
  end

  assign accept = i_resetn && grant_found && issue_allowed;

  // Issue stage and round-robin pointer. An accepted request is registered
  // here and presented to the datapath for exactly one cycle. The operand
  // registers keep their last values when nothing is accepted, which keeps
  // the datapath inputs quiet between operations. The pointer moves just
  // past the winner so that it has the lowest priority next time.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      rr_ptr      <= '0;
      issue_valid <= 1'b0;
      issue_id    <= '0;
      issue_op    <= 1'b0;
      o_op_a      <= '0;
      o_op_b      <= '0;
    end else begin
      issue_valid <= accept;
      if (accept) begin
        o_op_a   <= i_req_a[int'(grant_idx)*WIDTH +: WIDTH];
        o_op_b   <= i_req_b[int'(grant_idx)*WIDTH +: WIDTH];
        issue_op <= i_req_op[grant_idx];
        issue_id <= grant_idx;
        rr_ptr   <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
      end
    end
  end

  assign o_op_valid = issue_valid;

  // Tag pipeline. Each stage carries {valid, id, op} one cycle further
  // behind the issue strobe. The last stage lines up exactly with the cycle
  // in which the datapath shows the matching result, so that stage decides
  // what gets written into the FIFO.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      tag_valid <= '0;
      tag_op    <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_valid[0] <= issue_valid;
      tag_op[0]    <= issue_op;
      tag_id[0]    <= issue_id;
      for (int i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_op[i]    <= tag_op[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // The sum is narrower than a response, so it is zero-extended; the
  // product already has the full response width.
  assign capture_result = tag_op[LAT-1] ? i_mul_result : RW'(i_add_result);
  assign fifo_push      = tag_valid[LAT-1];
  assign fifo_pop       = (fifo_count != '0) && i_rsp_ready;

  // FIFO storage. The memory itself needs no reset: nothing is ever read
  // from an empty FIFO because the head outputs are forced to zero then.
  always_ff @(posedge i_clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= {tag_id[LAT-1], capture_result};
    end
  end

  // FIFO pointers and fill count. Pointers wrap explicitly so any depth
  // works, not just powers of two. The credit scheme guarantees a push
  // never meets a full FIFO, so there is no overflow guard on the write.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (fifo_pop) begin
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head of the FIFO drives the response port; an empty FIFO shows zeros
  // instead of whatever stale entry the read pointer happens to address.
  always_comb begin
    fifo_head    = fifo_mem[rd_ptr];
    o_rsp_valid  = (fifo_count != '0);
    o_rsp_id     = '0;
    o_rsp_result = '0;
    if (o_rsp_valid) begin
      o_rsp_id     = fifo_head[EW-1:RW];
      o_rsp_result = fifo_head[RW-1:0];
    end
  end

endmodule

// File: tb/tb_arith_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_arith_rr_arbiter
//
// Bench for arith_rr_arbiter with the default parameters. A behavioural
// datapath answers issued operations LAT cycles later and shows random
// values on its outputs whenever no real result is due. A reference model
// tracks the round-robin pointer and the outstanding-operation credit on
// its own, predicts the ready vector and issue-stage contents every cycle,
// and pushes each expected response (id, result, earliest visible cycle)
// onto a scoreboard queue that is compared against the response port.
// ---------------------------------------------------------------------------
module tb_arith_rr_arbiter;

  localparam int WIDTH      = 8;
  localparam int NREQ       = 4;
  localparam int LAT        = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int IDW        = $clog2(NREQ);

  logic                    i_clk = 1'b0;
  logic                    i_resetn;
  logic [NREQ-1:0]         i_req_valid;
  logic [NREQ-1:0]         o_req_ready;
  logic [NREQ-1:0]         i_req_op;
  logic [NREQ*WIDTH-1:0]   i_req_a;
  logic [NREQ*WIDTH-1:0]   i_req_b;
  logic                    o_op_valid;
  logic [WIDTH-1:0]        o_op_a;
  logic [WIDTH-1:0]        o_op_b;
  logic [WIDTH:0]          i_add_result;
  logic [2*WIDTH-1:0]      i_mul_result;
  logic                    o_rsp_valid;
  logic [IDW-1:0]          o_rsp_id;
  logic [2*WIDTH-1:0]      o_rsp_result;
  logic                    i_rsp_ready;

  typedef struct {
    logic [IDW-1:0]     id;
    logic [2*WIDTH-1:0] res;
    int                 due;
  } exp_t;

  exp_t                  sb_q[$];
  exp_t                  sb_e;
  int                    n_checks = 0;
  int                    n_fail = 0;
  int                    cyc = 0;
  int                    m_ptr = 0;
  int                    m_out = 0;
  logic                  m_iss_v = 1'b0;
  logic [WIDTH-1:0]      m_iss_a = '0;
  logic [WIDTH-1:0]      m_iss_b = '0;
  logic                  exp_acc = 1'b0;
  logic                  exp_pop = 1'b0;
  int                    exp_g = 0;
  logic [WIDTH-1:0]      exp_a = '0;
  logic [WIDTH-1:0]      exp_b = '0;
  logic                  exp_op = 1'b0;
  int                    mon_g;
  int                    mon_idx;
  logic [NREQ-1:0]       mon_ready;
  logic                  mon_rv;
  int                    dut_accepts = 0;
  int                    acc_base;
  logic [NREQ-1:0]       r_op;
  logic [NREQ*WIDTH-1:0] r_a;
  logic [NREQ*WIDTH-1:0] r_b;

  logic [LAT-1:0]        dp_v = '0;
  logic [WIDTH-1:0]      dp_a [LAT];
  logic [WIDTH-1:0]      dp_b [LAT];
  logic [WIDTH:0]        junk_add = '0;
  logic [2*WIDTH-1:0]    junk_mul = '0;

  arith_rr_arbiter #(
    .WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(i_clk),
    .i_resetn(i_resetn),
    .i_req_valid(i_req_valid),
    .o_req_ready(o_req_ready),
    .i_req_op(i_req_op),
    .i_req_a(i_req_a),
    .i_req_b(i_req_b),
    .o_op_valid(o_op_valid),
    .o_op_a(o_op_a),
    .o_op_b(o_op_b),
    .i_add_result(i_add_result),
    .i_mul_result(i_mul_result),
    .o_rsp_valid(o_rsp_valid),
    .o_rsp_id(o_rsp_id),
    .o_rsp_result(o_rsp_result),
    .i_rsp_ready(i_rsp_ready)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural datapath: operands seen with the issue strobe come back as
  // sum and product LAT cycles later; otherwise the outputs carry noise.
  always @(posedge i_clk) begin
    dp_v[0] <= o_op_valid;
    dp_a[0] <= o_op_a;
    dp_b[0] <= o_op_b;
    for (int i = 1; i < LAT; i++) begin
      dp_v[i] <= dp_v[i-1];
      dp_a[i] <= dp_a[i-1];
      dp_b[i] <= dp_b[i-1];
    end
    junk_add <= (WIDTH+1)'($urandom);
    junk_mul <= (2*WIDTH)'($urandom);
  end

  assign i_add_result = dp_v[LAT-1] ?
                        ((WIDTH+1)'(dp_a[LAT-1]) + (WIDTH+1)'(dp_b[LAT-1])) : junk_add;
  assign i_mul_result = dp_v[LAT-1] ?
                        ((2*WIDTH)'(dp_a[LAT-1]) * (2*WIDTH)'(dp_b[LAT-1])) : junk_mul;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Drives every request-side input plus the response consumer ready.
  task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [NREQ-1:0] op,
                               input logic [NREQ*WIDTH-1:0] a, input logic [NREQ*WIDTH-1:0] b,
                               input logic rsp_ready);
    i_req_valid = valid;
    i_req_op    = op;
    i_req_a     = a;
    i_req_b     = b;
    i_rsp_ready = rsp_ready;
  endtask

  task automatic nextCycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic randomOperands();
    r_op = NREQ'($urandom);
    r_a  = (NREQ*WIDTH)'($urandom);
    r_b  = (NREQ*WIDTH)'($urandom);
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req_ready",  64'(o_req_ready),  64'(0));
    checkOutput("rst_op_valid",   64'(o_op_valid),   64'(0));
    checkOutput("rst_op_a",       64'(o_op_a),       64'(0));
    checkOutput("rst_op_b",       64'(o_op_b),       64'(0));
    checkOutput("rst_rsp_valid",  64'(o_rsp_valid),  64'(0));
    checkOutput("rst_rsp_id",     64'(o_rsp_id),     64'(0));
    checkOutput("rst_rsp_result", 64'(o_rsp_result), 64'(0));
  endtask

  // Monitor on the falling edge: predict ready / issue / response outputs
  // from the model state and the inputs, compare, and latch what the next
  // rising edge should do (accept and/or pop).
  always @(negedge i_clk) begin
    exp_acc = 1'b0;
    exp_pop = 1'b0;
    if (i_resetn) begin
      mon_g = -1;
      for (int i = 0; i < NREQ; i++) begin
        mon_idx = (m_ptr + i) % NREQ;
        if (mon_g < 0 && i_req_valid[mon_idx]) mon_g = mon_idx;
      end
      mon_ready = '0;
      if (mon_g >= 0 && m_out < FIFO_DEPTH) mon_ready[mon_g] = 1'b1;
      checkOutput("req_ready", 64'(o_req_ready), 64'(mon_ready));
      if (|(i_req_valid & o_req_ready)) dut_accepts++;
      checkOutput("op_valid", 64'(o_op_valid), 64'(m_iss_v));
      if (m_iss_v) begin
        checkOutput("op_a", 64'(o_op_a), 64'(m_iss_a));
        checkOutput("op_b", 64'(o_op_b), 64'(m_iss_b));
      end
      mon_rv = (sb_q.size() > 0) && (sb_q[0].due <= cyc);
      checkOutput("rsp_valid", 64'(o_rsp_valid), 64'(mon_rv));
      if (mon_rv) begin
        checkOutput("rsp_id",     64'(o_rsp_id),     64'(sb_q[0].id));
        checkOutput("rsp_result", 64'(o_rsp_result), 64'(sb_q[0].res));
      end
      if (mon_ready != '0) begin
        exp_acc = 1'b1;
        exp_g   = mon_g;
        exp_a   = i_req_a[mon_g*WIDTH +: WIDTH];
        exp_b   = i_req_b[mon_g*WIDTH +: WIDTH];
        exp_op  = i_req_op[mon_g];
      end
      exp_pop = mon_rv && i_rsp_ready;
    end
  end

  // Model update on the rising edge: retire popped responses, register an
  // accepted request into the model issue stage and enqueue its response.
  always @(posedge i_clk) begin
    cyc++;
    if (!i_resetn) begin
      sb_q.delete();
      m_ptr   = 0;
      m_out   = 0;
      m_iss_v = 1'b0;
    end else begin
      if (exp_pop) begin
        sb_q.delete(0);
        m_out--;
      end
      m_iss_v = exp_acc;
      if (exp_acc) begin
        sb_e.id  = IDW'(exp_g);
        sb_e.res = exp_op ? ((2*WIDTH)'(exp_a) * (2*WIDTH)'(exp_b))
                          : ((2*WIDTH)'(exp_a) + (2*WIDTH)'(exp_b));
        sb_e.due = cyc + LAT + 1;
        sb_q.push_back(sb_e);
        m_ptr   = (exp_g + 1) % NREQ;
        m_out++;
        m_iss_a = exp_a;
        m_iss_b = exp_b;
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_resetn = 1'b0;
    applyStimulus('0, '0, '0, '0, 1'b0);
    nextCycle();
    nextCycle();
    checkResetOutputs();
    i_resetn = 1'b1;
    nextCycle();

    // Single add on requester 0: 200 + 100 = 300, visible four cycles on.
    $display("[TB] single add on req0");
    applyStimulus(4'b0001, 4'b0000, 32'h0000_00C8, 32'h0000_0064, 1'b1);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 32'h0000_00C8, 32'h0000_0064, 1'b1);
    checkOutput("t1_op_valid", 64'(o_op_valid), 64'(1));
    checkOutput("t1_op_a", 64'(o_op_a), 64'(200));
    checkOutput("t1_op_b", 64'(o_op_b), 64'(100));
    nextCycle();
    nextCycle();
    checkOutput("t1_rsp_early", 64'(o_rsp_valid), 64'(0));
    nextCycle();
    checkOutput("t1_rsp_valid", 64'(o_rsp_valid), 64'(1));
    checkOutput("t1_rsp_id", 64'(o_rsp_id), 64'(0));
    checkOutput("t1_rsp_result", 64'(o_rsp_result), 64'(300));
    nextCycle();
    nextCycle();

    // Single multiply on requester 2: 255 * 255 = 0xFE01, pointer moves to 3.
    $display("[TB] single mul on req2");
    applyStimulus(4'b0100, 4'b0100, 32'h00FF_0000, 32'h00FF_0000, 1'b1);
    nextCycle();
    applyStimulus(4'b0000, 4'b0000, 32'h00FF_0000, 32'h00FF_0000, 1'b1);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("t2_rsp_valid", 64'(o_rsp_valid), 64'(1));
    checkOutput("t2_rsp_id", 64'(o_rsp_id), 64'(2));
    checkOutput("t2_rsp_result", 64'(o_rsp_result), 64'(16'hFE01));
    nextCycle();
    nextCycle();

    // All requesters busy with the consumer always ready.
    $display("[TB] all requesters, consumer ready");
    randomOperands();
    applyStimulus(4'b1111, r_op, r_a, r_b, 1'b1);
    #1;
    checkOutput("t2_ptr_grant", 64'(o_req_ready), 64'(4'b1000));
    for (int i = 0; i < 24; i++) begin
      nextCycle();
      randomOperands();
      applyStimulus(4'b1111, r_op, r_a, r_b, 1'b1);
    end
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) nextCycle();

    // Consumer stalled: exactly FIFO_DEPTH accepts, then everything blocks.
    $display("[TB] consumer stalled");
    acc_base = dut_accepts;
    for (int i = 0; i < 10; i++) begin
      randomOperands();
      applyStimulus(4'b1111, r_op, r_a, r_b, 1'b0);
      nextCycle();
    end
    checkOutput("t4_accepts", 64'(dut_accepts - acc_base), 64'(FIFO_DEPTH));
    checkOutput("t4_blocked", 64'(o_req_ready), 64'(0));
    for (int i = 0; i < 12; i++) begin
      randomOperands();
      applyStimulus(4'b1111, r_op, r_a, r_b, 1'b1);
      nextCycle();
    end
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) nextCycle();

    // Pointer at 2 with only requesters 1 and 3 asking: 3, 1, 3, ...
    $display("[TB] alternating requesters 1 and 3");
    applyStimulus(4'b0010, 4'b0000, 32'h0000_0500, 32'h0000_0300, 1'b1);
    nextCycle();
    randomOperands();
    applyStimulus(4'b1010, r_op, r_a, r_b, 1'b1);
    #1;
    checkOutput("t5_first_grant", 64'(o_req_ready), 64'(4'b1000));
    for (int i = 0; i < 8; i++) begin
      nextCycle();
      randomOperands();
      applyStimulus(4'b1010, r_op, r_a, r_b, 1'b1);
    end
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) nextCycle();

    // Reset while two operations are in flight.
    $display("[TB] reset with operations in flight");
    applyStimulus(4'b0011, 4'b0001, 32'h0102_0709, 32'h0304_0906, 1'b1);
    nextCycle();
    nextCycle();
    applyStimulus(4'b0100, 4'b0000, 32'h0102_0709, 32'h0304_0906, 1'b1);
    #3;
    i_resetn = 1'b0;
    #1;
    checkResetOutputs();
    @(posedge i_clk);
    #3;
    i_resetn = 1'b1;
    applyStimulus(4'b0110, 4'b0000, 32'h0011_2200, 32'h0033_4400, 1'b1);
    #1;
    checkOutput("t6_grant_after_reset", 64'(o_req_ready), 64'(4'b0010));
    nextCycle();
    applyStimulus('0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 10; i++) nextCycle();

    checkOutput("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
